// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - two-requester round-robin arbiter and sequencer for the cache access port
// Captures one request at a time, holds the cache command through stalls, then pulses a one-cycle response.
module cache_port_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [DATA_WIDTH-1:0] cache_wdata,
  output logic                  cache_read,
  output logic                  cache_write,
  input  logic                  cache_stall,
  input  logic [DATA_WIDTH-1:0] cache_rdata,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  stall_cycles
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t state, nextState;
  logic   lastGrant;
  logic   owner;
  logic   isWrite;
  logic   grant;
  logic   anyValid;

  // Requester 1 wins when it is alone, or on a tie when requester 0 was served last.
  always_comb begin
    anyValid = req0_valid | req1_valid;
    grant    = req1_valid & (~req0_valid | ~lastGrant);
  end

  always_comb begin
    nextState   = state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    cache_read  = 1'b0;
    cache_write = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        req0_ready = req0_valid & ~grant;
        req1_ready = grant;
        if (anyValid) nextState = ISSUE;
      end
      ISSUE: begin
        cache_read  = ~isWrite;
        cache_write = isWrite;
        if (!cache_stall) nextState = RESP;
      end
      RESP: begin
        rsp0_valid = ~owner;
        rsp1_valid = owner;
        nextState  = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      lastGrant    <= 1'b1;
      owner        <= 1'b0;
      isWrite      <= 1'b0;
      cache_addr   <= '0;
      cache_wdata  <= '0;
      rsp0_rdata   <= '0;
      rsp1_rdata   <= '0;
      stall_cycles <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && anyValid) begin
        owner       <= grant;
        lastGrant   <= grant;
        isWrite     <= grant ? req1_write : req0_write;
        cache_addr  <= grant ? req1_addr  : req0_addr;
        cache_wdata <= grant ? req1_wdata : req0_wdata;
      end
      if (state == ISSUE) begin
        if (cache_stall) begin
          if (stall_cycles != {CNT_WIDTH{1'b1}}) stall_cycles <= stall_cycles + CNT_WIDTH'(1);
        end else if (!isWrite) begin
          if (owner) rsp1_rdata <= cache_rdata;
          else       rsp0_rdata <= cache_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb/tb_cache_port_arbiter.sv - vector table, randomized reference model and saturation run for cache_port_arbiter
module tb_cache_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_write, req1_valid, req1_write;
  logic [9:0]  req0_addr, req1_addr;
  logic [31:0] req0_wdata, req1_wdata;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic [9:0]  cache_addr;
  logic [31:0] cache_wdata, cache_rdata;
  logic        cache_read, cache_write, cache_stall, busy;
  logic [15:0] stall_cycles;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cache_port_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_read(cache_read), .cache_write(cache_write),
    .cache_stall(cache_stall), .cache_rdata(cache_rdata), .busy(busy), .stall_cycles(stall_cycles)
  );

  typedef struct {
    logic        rst, v0, w0, v1, w1, stall;
    logic [9:0]  a0, a1;
    logic [31:0] d0, d1, crdata;
    logic        rdy0, rdy1, rv0, rv1, crd, cwr, bsy;
    logic [31:0] rd0, rd1, cwd;
    logic [9:0]  caddr;
    logic [15:0] sc;
  } vec_t;

  typedef struct {
    bit          owner, write;
    logic [9:0]  addr;
    logic [31:0] data;
  } txn_t;

  vec_t tbl[$];
  vec_t t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Append the row under construction; one-cycle fields clear, held outputs carry over.
  task automatic push();
    tbl.push_back(t);
    t.rst = 0; t.v0 = 0; t.w0 = 0; t.v1 = 0; t.w1 = 0; t.stall = 0; t.crdata = 0;
    t.rdy0 = 0; t.rdy1 = 0; t.rv0 = 0; t.rv1 = 0; t.crd = 0; t.cwr = 0; t.bsy = 0;
  endtask

  task automatic drive(input logic r, input logic v0, input logic w0, input logic [9:0] a0, input logic [31:0] d0,
                       input logic v1, input logic w1, input logic [9:0] a1, input logic [31:0] d1,
                       input logic st, input logic [31:0] crd);
    reset = r; req0_valid = v0; req0_write = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_write = w1; req1_addr = a1; req1_wdata = d1;
    cache_stall = st; cache_rdata = crd;
  endtask

  task automatic chk_all(input string p, input logic rdy0, input logic rdy1, input logic rv0, input logic rv1,
                         input logic [31:0] rd0, input logic [31:0] rd1, input logic [9:0] ca,
                         input logic [31:0] cwd, input logic crd, input logic cwr, input logic bsy,
                         input logic [15:0] sc);
    chk({p, " req0_ready"}, req0_ready, rdy0);
    chk({p, " req1_ready"}, req1_ready, rdy1);
    chk({p, " rsp0_valid"}, rsp0_valid, rv0);
    chk({p, " rsp1_valid"}, rsp1_valid, rv1);
    chk({p, " rsp0_rdata"}, rsp0_rdata, rd0);
    chk({p, " rsp1_rdata"}, rsp1_rdata, rd1);
    chk({p, " cache_addr"}, cache_addr, ca);
    chk({p, " cache_wdata"}, cache_wdata, cwd);
    chk({p, " cache_read"}, cache_read, crd);
    chk({p, " cache_write"}, cache_write, cwr);
    chk({p, " busy"}, busy, bsy);
    chk({p, " stall_cycles"}, stall_cycles, sc);
  endtask

  function automatic int pick(bit v0, bit v1, int last);
    if (v0 && v1) return (last == 0) ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  initial begin
    txn_t        pend[$];
    txn_t        nt;
    bit          respDue;
    int          respOwner, lastOwner, stalls, choose;
    logic [31:0] mRd[2];
    logic [9:0]  mAddr;
    logic [31:0] mWdata;
    bit          rv, rw0, rw1, rst_, st;
    logic [9:0]  ra0, ra1;
    logic [31:0] rd0_, rd1_, rcd;
    txn_t        cur;
    bit          issuing;

    t = '{default: '0};
    push(); push();
    t.v0 = 1; t.a0 = 10'h005; t.rdy0 = 1; push();
    t.crdata = 32'd77; t.crd = 1; t.caddr = 10'h005; t.bsy = 1; push();
    t.rv0 = 1; t.rd0 = 32'd77; t.bsy = 1; push();
    push();
    t.v1 = 1; t.w1 = 1; t.a1 = 10'h3FF; t.d1 = 32'hDEADBEEF; t.rdy1 = 1; push();
    t.stall = 1; t.cwr = 1; t.caddr = 10'h3FF; t.cwd = 32'hDEADBEEF; t.bsy = 1; push();
    t.stall = 1; t.cwr = 1; t.bsy = 1; t.sc = 1; push();
    t.stall = 1; t.cwr = 1; t.bsy = 1; t.sc = 2; push();
    t.crdata = 32'h12345678; t.cwr = 1; t.bsy = 1; t.sc = 3; push();
    t.rv1 = 1; t.bsy = 1; push();
    push();
    t.rst = 1; push();
    t.caddr = 0; t.cwd = 0; t.rd0 = 0; t.rd1 = 0; t.sc = 0; t.d1 = 0;
    t.a0 = 10'h001; t.a1 = 10'h002;
    for (int k = 0; k < 4; k++) begin
      t.v0 = 1; t.v1 = 1; if (k % 2 == 0) t.rdy0 = 1; else t.rdy1 = 1; push();
      t.v0 = 1; t.v1 = 1; t.crdata = 32'h11 * (k + 1); t.crd = 1; t.caddr = (k % 2 == 0) ? 10'h001 : 10'h002;
      t.bsy = 1; push();
      t.v0 = 1; t.v1 = 1; t.bsy = 1;
      if (k % 2 == 0) begin t.rv0 = 1; t.rd0 = 32'h11 * (k + 1); end
      else begin t.rv1 = 1; t.rd1 = 32'h11 * (k + 1); end
      push();
    end
    t.v0 = 1; t.v1 = 1; t.rdy0 = 1; push();
    t.stall = 1; t.crd = 1; t.caddr = 10'h001; t.bsy = 1; push();
    t.stall = 1; t.rst = 1; t.crd = 1; t.bsy = 1; t.sc = 1; push();
    t.caddr = 0; t.rd0 = 0; t.rd1 = 0; t.sc = 0;
    t.stall = 1; push();
    t.v1 = 1; t.a1 = 10'h007; t.rdy1 = 1; push();
    t.crdata = 32'h55; t.crd = 1; t.caddr = 10'h007; t.bsy = 1; push();
    t.rv1 = 1; t.rd1 = 32'h55; t.bsy = 1; push();
    push();

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].v0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].w1, tbl[i].a1, tbl[i].d1,
            tbl[i].stall, tbl[i].crdata);
      #1;
      chk_all($sformatf("row%0d", i), tbl[i].rdy0, tbl[i].rdy1, tbl[i].rv0, tbl[i].rv1, tbl[i].rd0, tbl[i].rd1,
              tbl[i].caddr, tbl[i].cwd, tbl[i].crd, tbl[i].cwr, tbl[i].bsy, tbl[i].sc);
      @(posedge clk);
      #1;
    end

    // Randomized traffic against a transaction-level model.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    respDue = 0; respOwner = 0; lastOwner = 1; stalls = 0;
    mRd[0] = 0; mRd[1] = 0; mAddr = 0; mWdata = 0;
    for (int c = 0; c < 3000; c++) begin
      rst_ = ($urandom % 60) == 0;
      rv = $urandom_range(0, 2) != 0;
      rw0 = $urandom % 2; ra0 = 10'($urandom); rd0_ = $urandom;
      rw1 = $urandom % 2; ra1 = 10'($urandom); rd1_ = $urandom;
      st = ($urandom % 3) == 0;
      rcd = $urandom;
      begin
        bit v1b;
        v1b = $urandom_range(0, 2) != 0;
        drive(rst_, rv, rw0, ra0, rd0_, v1b, rw1, ra1, rd1_, st, rcd);
      end
      #1;
      issuing = pend.size() != 0;
      choose = (!issuing && !respDue) ? pick(req0_valid, req1_valid, lastOwner) : -1;
      cur = issuing ? pend[0] : '{default: '0};
      chk_all($sformatf("rnd%0d", c), choose == 0, choose == 1, respDue && respOwner == 0,
              respDue && respOwner == 1, mRd[0], mRd[1], mAddr, mWdata, issuing && !cur.write,
              issuing && cur.write, issuing || respDue, (stalls > 65535) ? 16'hFFFF : 16'(stalls));
      if (rst_) begin
        pend.delete(); respDue = 0; lastOwner = 1; stalls = 0;
        mRd[0] = 0; mRd[1] = 0; mAddr = 0; mWdata = 0;
      end else if (respDue) begin
        respDue = 0;
      end else if (issuing) begin
        if (st) stalls++;
        else begin
          if (!cur.write) mRd[cur.owner] = rcd;
          respOwner = cur.owner; respDue = 1;
          pend.delete(0);
        end
      end else if (choose >= 0) begin
        nt.owner = choose[0];
        nt.write = choose == 1 ? req1_write : req0_write;
        nt.addr  = choose == 1 ? req1_addr : req0_addr;
        nt.data  = choose == 1 ? req1_wdata : req0_wdata;
        pend.push_back(nt);
        lastOwner = choose; mAddr = nt.addr; mWdata = nt.data;
      end
      @(posedge clk);
      #1;
    end

    // Long stall run to push the counter past its ceiling.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    drive(0, 1, 0, 10'h003, 0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("sat accept", req0_ready, 1'b1);
    @(posedge clk);
    #1;
    req0_valid = 0;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat below ceiling", stall_cycles, 16'hFFFE);
    @(posedge clk);
    #1;
    chk("sat at ceiling", stall_cycles, 16'hFFFF);
    repeat (6) @(posedge clk);
    #1;
    chk("sat held", stall_cycles, 16'hFFFF);
    chk("sat cmd held", cache_read, 1'b1);
    chk("sat addr held", cache_addr, 10'h003);
    cache_stall = 0; cache_rdata = 32'd99;
    @(posedge clk);
    #1;
    chk("sat rsp valid", rsp0_valid, 1'b1);
    chk("sat rsp data", rsp0_rdata, 32'd99);
    chk("sat count kept", stall_cycles, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
Two-requester arbiter and sequencer for the single access port of the write-through caching system. Requester 0 is instruction fetch and requester 1 is load/store. Each request is captured with a valid/ready handshake, then issued as a mem_read or mem_write command that is held through cache stalls. A one-cycle response returns read data to the owning requester. Round-robin arbitration applies on simultaneous requests; a saturating stall-cycle counter is kept for performance monitoring.

Parameters:
ADDR_WIDTH, 10, word-address width (matches cache WordAddress)
DATA_WIDTH, 32, data width (matches cache DataIn/DataOut)
CNT_WIDTH, 16, width of stall-cycle counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req0_valid / req1_valid  in  1  request pending
req0_write / req1_write  in  1  1=write, 0=read
req0_addr / req1_addr  in  ADDR_WIDTH  word address
req0_wdata / req1_wdata  in  DATA_WIDTH  write data
req0_ready / req1_ready  out  1  request accepted this cycle
rsp0_valid / rsp1_valid  out  1  one-cycle completion pulse
rsp0_rdata / rsp1_rdata  out  DATA_WIDTH  read data, held until next read completion for that requester
cache_addr  out  ADDR_WIDTH  to cache WordAddress
cache_wdata  out  DATA_WIDTH  to cache DataIn
cache_read  out  1  to cache mem_read
cache_write  out  1  to cache mem_write
cache_stall  in  1  from cache stall
cache_rdata  in  DATA_WIDTH  from cache DataOut
busy  out  1  state != IDLE
stall_cycles  out  CNT_WIDTH  saturating count of ISSUE cycles with cache_stall=1

Behaviour:
- Reset (sync, active-high) values:
  - state=IDLE; last_grant=1, so requester 0 wins the first tie.
  - All outputs 0: ready, rsp_valid, rsp_rdata, cache_addr, cache_wdata, cache_read, cache_write, busy, stall_cycles.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - reqN_ready is combinational: state==IDLE and grant==N. At most one ready is high.
  - Grant rule: if only one valid, grant it. If both valid, grant the requester != last_grant.
  - At the edge with valid&ready: capture addr, wdata, write and owner into registers; set last_grant=owner; go to ISSUE.
  - No valid: stay in IDLE.
- ISSUE:
  - cache_addr and cache_wdata are driven from the captured registers and stay stable for the whole state.
  - cache_read = ~write, cache_write = write. Exactly one is high, and only in ISSUE.
  - Edge with cache_stall=1: stay in ISSUE; stall_cycles += 1, saturating at all-ones.
  - Edge with cache_stall=0: command completes. For a read, cache_rdata is captured into the owner's rsp_rdata. Go to RESP.
- RESP:
  - rsp_valid[owner]=1 for exactly this one cycle; unconditionally go to IDLE.
  - For writes, rsp_rdata is unchanged (ack only).
- Latency:
  - Accept at edge N; ISSUE occupies cycle N+1; on a hit (no stall), rsp_valid is high in cycle N+2; next accept is possible at end of cycle N+3.
  - Each stall cycle adds one. Throughput is at most one request per 3 cycles.
- Outside ISSUE: cache_read=cache_write=0; cache_addr and cache_wdata hold their last values.
- Requester may drop valid before ready with no effect. Request inputs are ignored outside IDLE.
- Simultaneous valid on both requesters: one is granted; the other keeps valid asserted and is granted at the next IDLE, with no starvation.
- Reset mid-ISSUE or mid-RESP: the transaction is abandoned, no rsp_valid is produced, and the cache command is low in the cycle after the reset edge.
- stall_cycles is cleared only by reset.

Test Plan:
- Reset held 2 cycles, then released with no requests -> all outputs 0; ready stays 0 because no valid is asserted.
- req0 read addr=10'h005, cache_stall=0, cache_rdata=32'd77 -> req0_ready in cycle 0; cache_read=1, cache_addr=5 in cycle 1; rsp0_valid=1, rsp0_rdata=77 in cycle 2; busy high for cycles 1-2.
- req1 write addr=10'h3FF, wdata=32'hDEADBEEF, cache_stall=1 for 3 cycles -> cache_write held for 4 cycles with addr/data stable; rsp1_valid one cycle later; stall_cycles=3; rsp1_rdata unchanged.
- Both valid continuously for 4 transactions after reset -> grant order 0,1,0,1; each rsp_valid goes only to the granted requester.
- Reset asserted during ISSUE with stall=1 -> cache_read low next cycle; no rsp_valid; stall_cycles=0; next request serviced normally.
- Force 2^16+5 stall cycles -> stall_cycles saturates at 16'hFFFF.
